// File: rtl/wb_mcu_bram_arb.sv
// Two-master Wishbone arbiter in front of a single-port BRAM.
// Round-robin grant, one transfer per three clocks, command latched at grant.
module wb_mcu_bram_arb #(
    parameter int ADR_WIDTH  = 10,
    parameter int DATA_WIDTH = 16,
    parameter int SEL_WIDTH  = 2
) (
    input  logic                  clk_i,
    input  logic                  resetn,

    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_we_i,
    input  logic [ADR_WIDTH-1:0]  m0_adr_i,
    input  logic [DATA_WIDTH-1:0] m0_dat_i,
    input  logic [SEL_WIDTH-1:0]  m0_sel_i,
    output logic [DATA_WIDTH-1:0] m0_dat_o,
    output logic                  m0_ack_o,

    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_we_i,
    input  logic [ADR_WIDTH-1:0]  m1_adr_i,
    input  logic [DATA_WIDTH-1:0] m1_dat_i,
    input  logic [SEL_WIDTH-1:0]  m1_sel_i,
    output logic [DATA_WIDTH-1:0] m1_dat_o,
    output logic                  m1_ack_o,

    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [ADR_WIDTH-1:0]  s_adr_o,
    output logic [DATA_WIDTH-1:0] s_dat_o,
    output logic [SEL_WIDTH-1:0]  s_sel_o,
    input  logic [DATA_WIDTH-1:0] s_dat_i,

    output logic [1:0]            gnt_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic                  r_owner;
    logic                  r_last_gnt;
    logic                  r_we;
    logic [ADR_WIDTH-1:0]  r_adr;
    logic [DATA_WIDTH-1:0] r_dat;
    logic [SEL_WIDTH-1:0]  r_sel;

    logic                  w_req0;
    logic                  w_req1;
    logic                  w_grant_en;
    logic                  w_grant_sel;
    logic                  w_cmd_we;
    logic [ADR_WIDTH-1:0]  w_cmd_adr;
    logic [DATA_WIDTH-1:0] w_cmd_dat;
    logic [SEL_WIDTH-1:0]  w_cmd_sel;
    logic                  w_in_access;
    logic                  w_in_ack;
    logic                  w_owner_cyc;

    assign w_req0 = m0_cyc_i & m0_stb_i;
    assign w_req1 = m1_cyc_i & m1_stb_i;

    // On a tie the master that did not win last time is served.
    always_comb begin
        w_grant_en  = 1'b0;
        w_grant_sel = 1'b0;
        if (r_state == ST_IDLE) begin
            if (w_req0 && w_req1) begin
                w_grant_en  = 1'b1;
                w_grant_sel = ~r_last_gnt;
            end else if (w_req0) begin
                w_grant_en  = 1'b1;
                w_grant_sel = 1'b0;
            end else if (w_req1) begin
                w_grant_en  = 1'b1;
                w_grant_sel = 1'b1;
            end
        end
    end

    assign w_cmd_we  = w_grant_sel ? m1_we_i  : m0_we_i;
    assign w_cmd_adr = w_grant_sel ? m1_adr_i : m0_adr_i;
    assign w_cmd_dat = w_grant_sel ? m1_dat_i : m0_dat_i;
    assign w_cmd_sel = w_grant_sel ? m1_sel_i : m0_sel_i;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_grant_en) w_state_nxt = ST_ACCESS;
            ST_ACCESS: w_state_nxt = ST_ACK;
            ST_ACK:    w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // last_gnt resets to master 1 so master 0 wins the first tie.
    always_ff @(posedge clk_i or negedge resetn) begin
        if (!resetn) begin
            r_owner    <= 1'b0;
            r_last_gnt <= 1'b1;
            r_we       <= 1'b0;
            r_adr      <= '0;
            r_dat      <= '0;
            r_sel      <= '0;
        end else if (w_grant_en) begin
            r_owner    <= w_grant_sel;
            r_last_gnt <= w_grant_sel;
            r_we       <= w_cmd_we;
            r_adr      <= w_cmd_adr;
            r_dat      <= w_cmd_dat;
            r_sel      <= w_cmd_sel;
        end
    end

    assign w_in_access = (r_state == ST_ACCESS);
    assign w_in_ack    = (r_state == ST_ACK);
    // A master that abandoned its cycle still gets its access, but no ack.
    assign w_owner_cyc = r_owner ? m1_cyc_i : m0_cyc_i;

    assign s_cyc_o = w_in_access;
    assign s_stb_o = w_in_access;
    assign s_we_o  = w_in_access & r_we;
    assign s_adr_o = r_adr;
    assign s_dat_o = r_dat;
    assign s_sel_o = r_sel;

    assign m0_ack_o = w_in_ack & ~r_owner & w_owner_cyc;
    assign m1_ack_o = w_in_ack &  r_owner & w_owner_cyc;
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    assign busy_o = (r_state != ST_IDLE);
    assign gnt_o  = busy_o ? (r_owner ? 2'b10 : 2'b01) : 2'b00;

endmodule
